// File: rtl/alu_seq_pkg.sv
// Shared opcodes, carry-select codes and sequencer states for alu_seq.
// ALU_F_MUL is only executed when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

    localparam logic [4:0] ALU_F_A           = 5'h00;
    localparam logic [4:0] ALU_F_B           = 5'h01;
    localparam logic [4:0] ALU_F_ADD         = 5'h02;
    localparam logic [4:0] ALU_F_SUB         = 5'h03;
    localparam logic [4:0] ALU_F_A_MINUS_ONE = 5'h04;
    localparam logic [4:0] ALU_F_ZERO        = 5'h05;
    localparam logic [4:0] ALU_F_NOT         = 5'h06;
    localparam logic [4:0] ALU_F_XOR         = 5'h07;
    localparam logic [4:0] ALU_F_AND         = 5'h08;
    localparam logic [4:0] ALU_F_OR          = 5'h09;
    localparam logic [4:0] ALU_F_SHIFT_LEFT  = 5'h0A;
    localparam logic [4:0] ALU_F_SHIFT_RIGHT = 5'h0B;
    localparam logic [4:0] ALU_F_SHL_N       = 5'h0C;
    localparam logic [4:0] ALU_F_SHR_N       = 5'h0D;
    localparam logic [4:0] ALU_F_MUL         = 5'h0E;

    localparam logic ALU_CSEL_UCIN  = 1'b0;
    localparam logic ALU_CSEL_SRCIN = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand, control and status bundle between microsequencer and alu_seq.
// The tri-state result bus y is a separate top-level port.
interface alu_seq_if #(
    parameter int WIDTH = 16
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       f;
    logic             csel;
    logic             ucin;
    logic             srcin;
    logic             start;
    logic             notOE;
    logic             cout;
    logic             zout;
    logic             busy;
    logic             done;

    modport master (
        output a, b, f, csel, ucin, srcin, start, notOE,
        input  cout, zout, busy, done
    );

    modport slave (
        input  a, b, f, csel, ucin, srcin, start, notOE,
        output cout, zout, busy, done
    );

endinterface

// File: rtl/alu_seq_core.sv
// Combinational single-cycle datapath of alu_seq.
// Multi-cycle opcodes decode here as illegal (result 0, carry 0).
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [4:0]       f_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] res_o,
    output logic             cout_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] ci;

    assign ci = (WIDTH+1)'(cin_i);

    always_comb begin
        sum    = '0;
        res_o  = '0;
        cout_o = 1'b0;
        case (f_i)
            ALU_F_A: begin
                sum    = {1'b0, a_i} + ci;
                res_o  = sum[WIDTH-1:0];
                cout_o = sum[WIDTH];
            end
            ALU_F_B: res_o = b_i;
            ALU_F_ADD: begin
                sum    = {1'b0, a_i} + {1'b0, b_i} + ci;
                res_o  = sum[WIDTH-1:0];
                cout_o = sum[WIDTH];
            end
            ALU_F_SUB: begin
                sum    = {1'b0, a_i} + {1'b0, ~b_i} + ci;
                res_o  = sum[WIDTH-1:0];
                cout_o = sum[WIDTH];
            end
            ALU_F_A_MINUS_ONE: begin
                sum    = {1'b0, a_i} + {1'b0, {WIDTH{1'b1}}} + ci;
                res_o  = sum[WIDTH-1:0];
                cout_o = sum[WIDTH];
            end
            ALU_F_ZERO: res_o = '0;
            ALU_F_NOT:  res_o = ~a_i;
            ALU_F_XOR:  res_o = a_i ^ b_i;
            ALU_F_AND:  res_o = a_i & b_i;
            ALU_F_OR:   res_o = a_i | b_i;
            ALU_F_SHIFT_LEFT: begin
                res_o  = a_i << 1;
                cout_o = a_i[WIDTH-1];
            end
            ALU_F_SHIFT_RIGHT: begin
                res_o  = a_i >> 1;
                cout_o = a_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with N-bit shifts and optional shift-add
// multiply (enabled by defining ALU_SEQ_MUL_EN).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             notReset,
    alu_seq_if.slave         bus,
    output wire  [WIDTH-1:0] y
);

    alu_state_t       state_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [4:0]       f_q;
    logic [CNTW-1:0]  cnt_q;
    logic [WIDTH-1:0] res_q;
    logic             cout_q, zout_q, busy_q, done_q;

    logic             cin;
    logic [WIDTH-1:0] core_res;
    logic             core_co;
    logic [WIDTH-1:0] step_res;
    logic             step_co;
    logic [CNTW-1:0]  n_in;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     psum;
`endif

    assign cin  = (bus.csel == ALU_CSEL_UCIN) ? bus.ucin : bus.srcin;
    assign n_in = bus.b[CNTW-1:0];

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .a_i    (bus.a),
        .b_i    (bus.b),
        .f_i    (bus.f),
        .cin_i  (cin),
        .res_o  (core_res),
        .cout_o (core_co)
    );

    // One RUN step: shift a_q by one, or add one partial product.
    always_comb begin
        a_d      = a_q;
        step_res = '0;
        step_co  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        prod_d = prod_q;
        psum   = '0;
`endif
        case (f_q)
            ALU_F_SHL_N: begin
                a_d      = a_q << 1;
                step_co  = a_q[WIDTH-1];
                step_res = a_d;
            end
            ALU_F_SHR_N: begin
                a_d      = a_q >> 1;
                step_co  = a_q[0];
                step_res = a_d;
            end
`ifdef ALU_SEQ_MUL_EN
            ALU_F_MUL: begin
                psum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                         + (prod_q[0] ? {1'b0, a_q} : '0);
                prod_d   = {psum, prod_q[WIDTH-1:1]};
                step_res = prod_d[WIDTH-1:0];
                step_co  = |prod_d[2*WIDTH-1:WIDTH];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q <= IDLE;
            a_q     <= '0;
            f_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            zout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                // FINISH accepts a new start exactly like IDLE
                IDLE, FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (bus.start) begin
                        a_q <= bus.a;
                        f_q <= bus.f;
                        if (bus.f == ALU_F_SHL_N || bus.f == ALU_F_SHR_N) begin
                            if (n_in == '0) begin
                                res_q   <= bus.a;
                                cout_q  <= 1'b0;
                                zout_q  <= (bus.a == '0);
                                done_q  <= 1'b1;
                                state_q <= FINISH;
                            end else begin
                                cnt_q   <= n_in - CNTW'(1);
                                busy_q  <= 1'b1;
                                state_q <= RUN;
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        else if (bus.f == ALU_F_MUL) begin
                            prod_q  <= {{WIDTH{1'b0}}, bus.b};
                            cnt_q   <= CNTW'(WIDTH - 1);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
`endif
                        else begin
                            res_q   <= core_res;
                            cout_q  <= core_co;
                            zout_q  <= (core_res == '0);
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    cnt_q <= cnt_q - CNTW'(1);
`ifdef ALU_SEQ_MUL_EN
                    prod_q <= prod_d;
`endif
                    if (cnt_q == '0) begin
                        res_q   <= step_res;
                        cout_q  <= step_co;
                        zout_q  <= (step_res == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FINISH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cout = cout_q;
    assign bus.zout = zout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign y        = bus.notOE ? {WIDTH{1'bz}} : res_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16).
// MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clock;
    logic        notReset;
    wire  [15:0] y;
    int          n_chk;
    int          n_fail;

    alu_seq_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .clock    (clock),
        .notReset (notReset),
        .bus      (bus),
        .y        (y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic        cs;
        logic        uc;
        logic        sc;
        logic [15:0] y;
        logic        co;
        logic        z;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [4:0] fi, input logic [15:0] ai,
                         input logic [15:0] bi, input logic cs,
                         input logic uc, input logic sc,
                         output int lat, output int bcnt);
        bus.f     = fi;
        bus.a     = ai;
        bus.b     = bi;
        bus.csel  = cs;
        bus.ucin  = uc;
        bus.srcin = sc;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!bus.done && lat < 200) begin
            if (bus.busy) bcnt++;
            @(posedge clock); #1;
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic chk_res(input string tag, input int lat, input int elat,
                           input logic [15:0] ey, input logic eco,
                           input logic ez);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_y"}, {16'h0, y}, {16'h0, ey});
        check({tag, "_cout"}, {31'h0, bus.cout}, {31'h0, eco});
        check({tag, "_zout"}, {31'h0, bus.zout}, {31'h0, ez});
    endtask

    initial begin
        int lat, bcnt, dcnt, first;
        logic zok;
        n_chk     = 0;
        n_fail    = 0;
        notReset  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.f     = '0;
        bus.csel  = ALU_CSEL_SRCIN;
        bus.ucin  = 1'b0;
        bus.srcin = 1'b0;
        bus.start = 1'b0;
        bus.notOE = 1'b0;

        vt[0] = '{ALU_F_SHIFT_LEFT,  16'h8001, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
        vt[1] = '{ALU_F_SHIFT_RIGHT, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
        vt[2] = '{ALU_F_A_MINUS_ONE, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vt[3] = '{ALU_F_A,           16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[4] = '{ALU_F_B,           16'h0000, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0};
        vt[5] = '{ALU_F_NOT,         16'h0F0F, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hF0F0, 1'b0, 1'b0};
        vt[6] = '{ALU_F_AND,         16'hFF00, 16'h0FF0, 1'b1, 1'b0, 1'b1, 16'h0F00, 1'b0, 1'b0};
        vt[7] = '{5'h1F,             16'h1234, 16'h5678, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};

        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_cout", {31'h0, bus.cout}, 32'h0);
        check("rst_zout", {31'h0, bus.zout}, 32'h0);
        check("rst_y", {16'h0, y}, 32'h0);
        notReset = 1'b1;
        @(posedge clock); #1;

        do_op(ALU_F_ADD, 16'hFFFF, 16'h0001, ALU_CSEL_SRCIN, 1'b1, 1'b0, lat, bcnt);
        chk_res("add_wrap", lat, 1, 16'h0000, 1'b1, 1'b1);
        @(posedge clock); #1;
        check("done_pulse", {31'h0, bus.done}, 32'h0);

        do_op(ALU_F_SUB, 16'h0001, 16'h0010, ALU_CSEL_SRCIN, 1'b0, 1'b1, lat, bcnt);
        chk_res("sub", lat, 1, 16'hFFF1, 1'b0, 1'b0);
        do_op(ALU_F_ADD, 16'hF031, 16'h0010, ALU_CSEL_UCIN, 1'b1, 1'b0, lat, bcnt);
        chk_res("add_ucin", lat, 1, 16'hF042, 1'b0, 1'b0);

        bus.notOE = 1'b1;
        #1;
        zok = (y === 16'hzzzz) || (y === 16'h0000);
        check("noe_z", {31'h0, zok}, 32'h1);
        bus.notOE = 1'b0;
        #1;
        check("noe_back", {16'h0, y}, 32'h0000F042);

        // still in the FINISH cycle of the ADD: a new start must be taken
        bus.f     = ALU_F_XOR;
        bus.a     = 16'hA5A5;
        bus.b     = 16'h0FF0;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("fin_start_done", {31'h0, bus.done}, 32'h1);
        check("fin_start_y", {16'h0, y}, 32'h0000AA55);

        for (int i = 0; i < 8; i++) begin
            do_op(vt[i].f, vt[i].a, vt[i].b, vt[i].cs, vt[i].uc, vt[i].sc, lat, bcnt);
            chk_res($sformatf("vec%0d", i), lat, 1, vt[i].y, vt[i].co, vt[i].z);
        end

        do_op(ALU_F_SHL_N, 16'h8FA1, 16'h0004, ALU_CSEL_SRCIN, 1'b0, 1'b0, lat, bcnt);
        chk_res("shl4", lat, 5, 16'hFA10, 1'b0, 1'b0);
        check("shl4_busy", bcnt, 4);
        do_op(ALU_F_SHR_N, 16'hF031, 16'h0000, ALU_CSEL_SRCIN, 1'b0, 1'b0, lat, bcnt);
        chk_res("shr0", lat, 1, 16'hF031, 1'b0, 1'b0);

        bus.f     = ALU_F_SHR_N;
        bus.a     = 16'h8000;
        bus.b     = 16'h000F;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        dcnt  = 0;
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            if (bus.done) begin
                dcnt++;
                if (first == 0) first = k;
            end
            if (k == 8) check("shr15_hold", {16'h0, y}, 32'h0000F031);
            if (k == 5) begin
                bus.f     = ALU_F_ZERO;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock); #1;
        end
        check("shr15_first", first, 16);
        check("shr15_count", dcnt, 1);
        check("shr15_y", {16'h0, y}, 32'h00000001);
        check("shr15_cout", {31'h0, bus.cout}, 32'h0);

        do_op(ALU_F_SHL_N, 16'h0001, 16'h0001, ALU_CSEL_SRCIN, 1'b0, 1'b0, lat, bcnt);
        chk_res("shl1", lat, 2, 16'h0002, 1'b0, 1'b0);

        bus.f     = ALU_F_SHL_N;
        bus.a     = 16'h8FA1;
        bus.b     = 16'h0004;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        notReset = 1'b0;
        #1;
        check("arst_busy", {31'h0, bus.busy}, 32'h0);
        check("arst_done", {31'h0, bus.done}, 32'h0);
        check("arst_y", {16'h0, y}, 32'h0);
        check("arst_cout", {31'h0, bus.cout}, 32'h0);
        check("arst_zout", {31'h0, bus.zout}, 32'h0);
        @(posedge clock); #1;
        notReset = 1'b1;
        @(posedge clock); #1;
        do_op(ALU_F_ADD, 16'h0002, 16'h0003, ALU_CSEL_SRCIN, 1'b0, 1'b0, lat, bcnt);
        chk_res("post_rst", lat, 1, 16'h0005, 1'b0, 1'b0);

`ifdef ALU_SEQ_MUL_EN
        do_op(ALU_F_MUL, 16'h0100, 16'h0100, ALU_CSEL_SRCIN, 1'b0, 1'b1, lat, bcnt);
        chk_res("mul_ovf", lat, 17, 16'h0000, 1'b1, 1'b1);
        do_op(ALU_F_MUL, 16'h00FF, 16'h0003, ALU_CSEL_SRCIN, 1'b0, 1'b1, lat, bcnt);
        chk_res("mul", lat, 17, 16'h02FD, 1'b0, 1'b0);
`else
        do_op(ALU_F_MUL, 16'h00FF, 16'h0003, ALU_CSEL_SRCIN, 1'b0, 1'b1, lat, bcnt);
        chk_res("mul_off", lat, 1, 16'h0000, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 16-bit combinational ALU.
- Adds a start/done handshake and multi-cycle operations: shift-by-N and an optional shift-add multiply.
- Keeps the carry-select scheme (microsequencer vs. status carry) and the active-low tri-state result bus.
- Sits between register file and data bus; driven by the microsequencer.

Parameters:
- WIDTH, 16: datapath width in bits; must be at least 4.
- CNTW, $clog2(WIDTH): width of the shift count and of the internal cycle counter.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- notReset  in  1  asynchronous, active-low reset.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; b[CNTW-1:0] is the shift count for N-shifts.
- f  in  5  operation code (alu_seq_pkg constants).
- csel  in  1  carry select: ALU_CSEL_UCIN picks ucin, ALU_CSEL_SRCIN picks srcin.
- ucin  in  1  carry in from microsequencer.
- srcin  in  1  carry in from status register.
- start  in  1  request pulse; accepted only when busy=0.
- notOE  in  1  active-low output enable for y.
- y  out  WIDTH  result register when notOE=0, else all-Z.
- cout  out  1  registered carry/overflow flag.
- zout  out  1  registered zero flag (result == 0).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when result and flags are valid.

Behaviour:
Reset (async, notReset=0):
- result=0, cout=0, zout=0, busy=0, done=0, state IDLE.
- y is Z unless notOE=0, in which case it drives 0.
- Reset during RUN aborts the operation; nothing partial is kept.

State machine IDLE -> RUN -> FINISH -> IDLE:
- IDLE, start=1: latch a, b, f and cin (ucin if csel=ALU_CSEL_UCIN, else srcin). busy=1.
- Single-cycle ops: go straight to FINISH; result and flags are written at that edge.
- Multi-cycle ops: go to RUN with counter loaded.
- RUN: one step per cycle until counter reaches 0, then FINISH.
- FINISH: done=1 for exactly one cycle, busy=0; back to IDLE.
- Latency: single-cycle ops, done 1 cycle after start. SHL_N/SHR_N with count n, done n+1 cycles after start. MUL, done WIDTH+1 cycles after start.
- start while busy=1 is ignored; there is no queueing.
- start in the FINISH cycle is accepted. The next op begins the following cycle, and done drops as normal.

Single-cycle ops (result, cout); arithmetic is modulo 2^WIDTH, cout is the carry out of bit WIDTH-1:
- A: a+cin.
- B: b, cout=0.
- ADD: a+b+cin.
- SUB: a+~b+cin, i.e. a-b-1+cin; cout=1 means no borrow.
- A_MINUS_ONE: a+all-ones+cin.
- ZERO: 0, cout=0.
- NOT: ~a, cout=0.
- XOR, AND, OR: bitwise a op b, cout=0.
- SHIFT_LEFT: a<<1, cout=a[WIDTH-1].
- SHIFT_RIGHT: a>>1 (logical), cout=a[0].

Multi-cycle ops:
- SHL_N / SHR_N: shift the latched a one bit per RUN cycle, n=b[CNTW-1:0] times, zero fill. cout = last bit shifted out.
- n=0: result=a, cout=0, no RUN cycles.
- MUL: present only with the optional feature (see Optional Feature).

Flags and output:
- zout is computed from the final result at the same edge as cout.
- Illegal or unknown f: result=0, cout=0, zout=1, single-cycle.
- result, cout and zout hold until the next operation's FINISH. They are not altered by start or by RUN.
- notOE is purely combinational on y: Z or the result register, independent of state.

Optional Feature:
Macro ALU_SEQ_MUL_EN.
- Defined: ALU_F_MUL = unsigned a*b, shift-add, one partial product per RUN cycle, WIDTH RUN cycles.
  - result = low WIDTH bits.
  - cout = 1 if any of the high WIDTH bits is nonzero.
  - cin is ignored.
- Undefined: ALU_F_MUL is decoded as illegal (result=0, cout=0, zout=1, single-cycle). The multiplier accumulator is not synthesised.

Decomposition:
Package alu_seq_pkg holds:
- all ALU_F_* opcode constants: existing codes kept, plus ALU_F_SHL_N, ALU_F_SHR_N, ALU_F_MUL;
- ALU_CSEL_UCIN and ALU_CSEL_SRCIN;
- the state enum IDLE/RUN/FINISH.

Sub-module alu_seq_core:
- purely combinational single-cycle datapath: (a, b, f, cin) -> (result, cout);
- the sequencer/shift/multiply logic stays in alu_seq.

Test Plan (WIDTH=16):
1. ADD a=FFFF b=0001 cin=0 (srcin) -> done after 1 cycle, y=0000, cout=1, zout=1. Same with notOE=1 -> y=ZZZZ.
2. SUB a=0001 b=0010 srcin=1 -> y=FFF1, cout=0. Then csel=UCIN, ucin=1, srcin=0, ADD F031+0010 -> y=F042, cout=0.
3. SHL_N a=8FA1 b=0004 -> busy for 4 RUN cycles, done at cycle 5, y=FA10, cout=0. SHR_N a=F031 b=0000 -> y=F031, cout=0, done at cycle 1.
4. start pulsed again mid-SHR_N (a=8000 b=000F) -> ignored, y=0001, cout=0, done exactly once at cycle 16.
5. notReset low during RUN of SHL_N -> busy=0, done=0, y=0000 (notOE=0), cout=0, zout=0 immediately. The next start works normally.
6. With ALU_SEQ_MUL_EN: MUL 0100*0100 -> y=0000, cout=1, zout=1, done at cycle 17; MUL 00FF*0003 -> y=02FD, cout=0. Without the macro: MUL -> y=0000, cout=0, zout=1, done at cycle 1.
